fp8_accum: RTL and testbench

FP8_ACCUM -- requirements
Module: fp8_accum

---
 rtl/fp8_pkg.sv | 18 +
 rtl/fp8_accum_if.sv | 35 +++
 rtl/fp8_to_fixed.sv | 31 +++
 rtl/fp8_accum.sv | 145 ++++++++++++++
 tb/tb_fp8_accum.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fp8_pkg.sv
// Shared constants and FSM state type for the FP8 accumulator.
// FP8 layout is {sign, exp[2:0], man[3:0]} with bias 3; the fixed-point domain is in units of 2^-6.
package fp8_pkg;

    localparam int unsigned EXP_W   = 3;
    localparam int unsigned MAN_W   = 4;
    localparam int unsigned BIAS    = 3;
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned FRAC_W  = 6;
    localparam int unsigned MAG_MAX = 2047;

    typedef enum logic [1:0] {
        StAcc,
        StNorm,
        StOut
    } state_e;

endpackage

// File: rtl/fp8_accum_if.sv
// Stream bundle for the accumulator: FP8 beats in, one FP8 run result out.
interface fp8_accum_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf
    );

endinterface

// File: rtl/fp8_to_fixed.sv
// Combinational FP8 decode into a signed fixed-point value in units of 2^-6.
module fp8_to_fixed
    import fp8_pkg::*;
(
    input  logic [7:0]              i_fp8,
    output logic signed [ACC_W-1:0] o_fixed
);

    // A normal (16+m)*2^(e-BIAS-MAN_W) in 2^-FRAC_W units is ((16+m) << e) >> this amount.
    localparam int unsigned NORM_RSH = BIAS + MAN_W - FRAC_W;

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic [ACC_W-1:0] w_mag;

    assign w_exp = i_fp8[6:4];
    assign w_man = i_fp8[3:0];

    always_comb begin
        w_mag = '0;
        if (w_exp == '0) begin
            w_mag = ACC_W'(w_man);
        end else begin
            w_mag = (ACC_W'({1'b1, w_man}) << w_exp) >> NORM_RSH;
        end
    end

    // 0x80 decodes to -0, which is plain zero in two's complement.
    assign o_fixed = i_fp8[7] ? -$signed(w_mag) : $signed(w_mag);

endmodule

// File: rtl/fp8_accum.sv
// Saturating FP8 run accumulator: sums beats in fixed point, then re-encodes the run total
// to FP8 with an iterative one-bit-per-cycle normaliser.
module fp8_accum
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    fp8_accum_if.slave bus
);

    localparam int unsigned MAG_W = ACC_W - 1;
    // Bit that holds the hidden one once the magnitude is aligned for exp_cnt.
    localparam int unsigned HID = MAN_W + FRAC_W;

    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W + 1)'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;
    localparam logic [MAG_W-1:0]      MAG_LIM = MAG_W'(MAG_MAX);

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic                     r_ovf;
    logic                     w_ovf_nxt;
    logic [MAG_W-1:0]         r_norm_mag;
    logic [MAG_W-1:0]         w_norm_mag_nxt;
    logic [EXP_W-1:0]         r_exp_cnt;
    logic [EXP_W-1:0]         w_exp_cnt_nxt;
    logic                     r_sign;
    logic                     w_sign_nxt;
    logic [7:0]               r_out_data;
    logic [7:0]               w_out_data_nxt;
    logic                     r_out_ovf;
    logic                     w_out_ovf_nxt;

    logic signed [ACC_W-1:0]  w_beat_val;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W-1:0]  w_acc_sat;
    logic                     w_clamp;
    logic [MAG_W-1:0]         w_abs;
    logic [MAN_W-1:0]         w_man_sel;

    fp8_to_fixed u_decode (
        .i_fp8   (bus.in_data),
        .o_fixed (w_beat_val)
    );

    // One guard bit keeps the raw sum exact before clamping.
    assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_beat_val[ACC_W-1], w_beat_val};

    always_comb begin
        w_clamp   = 1'b0;
        w_acc_sat = w_sum[ACC_W-1:0];
        if (w_sum > SUM_MAX) begin
            w_clamp   = 1'b1;
            w_acc_sat = SUM_MAX[ACC_W-1:0];
        end else if (w_sum < SUM_MIN) begin
            w_clamp   = 1'b1;
            w_acc_sat = SUM_MIN[ACC_W-1:0];
        end
    end

    assign w_abs     = w_acc_sat[ACC_W-1] ? MAG_W'(-w_acc_sat) : MAG_W'(w_acc_sat);
    assign w_man_sel = (r_exp_cnt != '0) ? r_norm_mag[HID-1 -: MAN_W] : r_norm_mag[HID -: MAN_W];

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_ovf_nxt      = r_ovf;
        w_norm_mag_nxt = r_norm_mag;
        w_exp_cnt_nxt  = r_exp_cnt;
        w_sign_nxt     = r_sign;
        w_out_data_nxt = r_out_data;
        w_out_ovf_nxt  = r_out_ovf;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;

        unique case (r_state)
            StAcc: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_acc_nxt = w_acc_sat;
                    w_ovf_nxt = r_ovf | w_clamp;
                    if (bus.in_last) begin
                        w_norm_mag_nxt = w_abs;
                        w_exp_cnt_nxt  = '1;
                        w_sign_nxt     = w_acc_sat[ACC_W-1];
                        w_state_nxt    = StNorm;
                    end
                end
            end
            StNorm: begin
                if (r_norm_mag > MAG_LIM) begin
                    w_out_data_nxt = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                    w_out_ovf_nxt  = r_ovf;
                    w_state_nxt    = StOut;
                end else if (r_norm_mag[HID] || (r_exp_cnt == '0)) begin
                    w_out_data_nxt = {r_sign, r_exp_cnt, w_man_sel};
                    w_out_ovf_nxt  = r_ovf;
                    w_state_nxt    = StOut;
                end else begin
                    w_norm_mag_nxt = r_norm_mag << 1;
                    w_exp_cnt_nxt  = r_exp_cnt - 1'b1;
                end
            end
            StOut: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = StAcc;
                end
            end
            default: begin
                w_state_nxt = StAcc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StAcc;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_norm_mag <= '0;
            r_exp_cnt  <= '0;
            r_sign     <= 1'b0;
            r_out_data <= 8'h00;
            r_out_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_ovf      <= w_ovf_nxt;
            r_norm_mag <= w_norm_mag_nxt;
            r_exp_cnt  <= w_exp_cnt_nxt;
            r_sign     <= w_sign_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_ovf  <= w_out_ovf_nxt;
        end
    end

    assign bus.out_data = r_out_data;
    assign bus.out_ovf  = r_out_ovf;

endmodule

// File: tb/tb_fp8_accum.sv
// Randomised bench for fp8_accum against a value-level reference model of the FP8 sum.
module tb_fp8_accum;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp8_accum_if bus ();

    fp8_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] q_beats[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Real value of an FP8 code in units of 2^-6.
    function automatic int fp8_val(input logic [7:0] b);
        int e;
        int m;
        int mag;
        e   = int'(b[6:4]);
        m   = int'(b[3:0]);
        mag = (e == 0) ? m : (16 + m) * (2 ** (e - 1));
        return b[7] ? -mag : mag;
    endfunction

    // Sum the queued run with saturation, then pick the largest FP8 code not above |sum|.
    task automatic model(output logic [7:0] exp_data, output logic exp_ovf, output int exp_lat);
        int acc;
        int mag;
        int e;
        int m;
        logic neg;
        acc     = 0;
        exp_ovf = 1'b0;
        foreach (q_beats[i]) begin
            acc += fp8_val(q_beats[i]);
            if (acc > 32767) begin
                acc     = 32767;
                exp_ovf = 1'b1;
            end else if (acc < -32767) begin
                acc     = -32767;
                exp_ovf = 1'b1;
            end
        end
        neg = (acc < 0);
        mag = neg ? -acc : acc;
        if (mag == 0) begin
            exp_data = 8'h00;
            exp_lat  = 8;
        end else if (mag > 2047) begin
            exp_data = {neg, 7'h7F};
            exp_lat  = 1;
        end else begin
            e = 0;
            for (int k = 7; k >= 1; k--) begin
                if (e == 0 && mag >= (16 << (k - 1))) e = k;
            end
            m        = (e > 0) ? (mag >> (e - 1)) - 16 : mag;
            exp_data = {neg, 3'(e), 4'(m)};
            exp_lat  = 8 - e;
        end
    endtask

    task automatic do_run(input string name, input int hold);
        logic [7:0] exp_data;
        logic       exp_ovf;
        int         exp_lat;
        int         lat;
        model(exp_data, exp_ovf, exp_lat);
        foreach (q_beats[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = q_beats[i];
            bus.in_last  = (i == q_beats.size() - 1);
            if (i == 0) check_eq({name, "/in_ready_acc"}, 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        // Upstream keeps presenting a junk beat; it must be ignored until the result drains.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'b1;
        check_eq({name, "/in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({name, "/out_valid"}, 32'(bus.out_valid), 32'd1);
        if (!bus.out_valid) begin
            bus.in_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        check_eq({name, "/latency"}, 32'(lat), 32'(exp_lat));
        check_eq({name, "/out_data"}, 32'(bus.out_data), 32'(exp_data));
        check_eq({name, "/out_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq({name, "/hold_data"}, 32'(bus.out_data), 32'(exp_data));
            check_eq({name, "/hold_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
            check_eq({name, "/hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq({name, "/drained"}, 32'(bus.out_valid), 32'd0);
        check_eq({name, "/in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset/out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset/in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset/out_data", 32'(bus.out_data), 32'h00);
        check_eq("reset/out_ovf", 32'(bus.out_ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        q_beats = '{8'h30, 8'h30};
        do_run("sum128", 0);
        q_beats = '{8'h38, 8'hB0};
        do_run("mixed_sign", 1);
        q_beats = '{8'h80};
        do_run("neg_zero", 0);
        q_beats = '{8'h01, 8'h01};
        do_run("subnormal", 0);
        q_beats = '{8'h7F, 8'h7F};
        do_run("mag_sat", 0);
        q_beats = {};
        repeat (17) q_beats.push_back(8'h7F);
        do_run("acc_clamp", 2);
        q_beats = '{8'h30, 8'h30};
        do_run("backpressure", 3);

        // Reset in the middle of normalisation must drop the run without emitting anything.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h30;
        bus.in_last  = 1'b0;
        @(posedge clk); #1;
        bus.in_last  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check_eq("rst_norm/out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_norm/in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_norm/no_result", 32'(bus.out_valid), 32'd0);
        q_beats = '{8'h30};
        do_run("after_rst", 0);

        for (int r = 0; r < 60; r++) begin
            int len;
            int mode;
            q_beats = {};
            mode    = int'($urandom_range(0, 3));
            len     = (mode == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                if (mode == 0) q_beats.push_back({1'($urandom), 3'b111, 4'($urandom)});
                else if (mode == 1) q_beats.push_back({1'($urandom), 3'b000, 4'($urandom)});
                else q_beats.push_back(8'($urandom));
            end
            do_run($sformatf("rand%0d", r), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
